// File: rtl/fetch_buffer.sv
// Instruction prefetch queue between fetch and decode.
// Holds {instr, pc} pairs captured on instruction-memory hits, hands them to
// decode in order over valid/ready, throttles fetch when full, flushes on a
// redirect and stops fetching once a HALT has been queued.
module fetch_buffer #(
  parameter int          DEPTH   = 4,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [31:0]                imemaddr,
  input  logic [31:0]                imemload,
  input  logic                       ihit,
  output logic                       imemREN,
  output logic                       pc_advance,
  input  logic                       redirect,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [31:0]                dec_instr,
  output logic [31:0]                dec_pc,
  output logic [31:0]                dec_npc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       halt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] HALT_SEEN = 2'd1;
  localparam logic [1:0] HALTED    = 2'd2;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic          push, pop, flush;

  assign imemREN    = (state_q == RUN) && (count_q < CW'(DEPTH));
  assign push       = ihit && imemREN && !redirect;
  assign pc_advance = push;
  assign dec_valid  = (count_q != '0) && (state_q != HALTED);
  assign pop        = dec_valid && dec_ready && !redirect;
  assign flush      = redirect && (state_q != HALTED);

  assign dec_instr = instr_q[rd_ptr_q];
  assign dec_pc    = pc_q[rd_ptr_q];
  assign dec_npc   = dec_pc + 32'd4;
  assign count     = count_q;
  assign halt      = (state_q == HALTED);

  // Entry storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= imemload;
      pc_q[wr_ptr_q]    <= imemaddr;
    end
  end

  // Next-state for pointers, occupancy and halt tracking.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (flush) begin
      // Same-cycle push is already suppressed by redirect, so wr_ptr_q is final.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
      if (state_q == HALT_SEEN) state_d = RUN;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (state_q == RUN && push && imemload[31:26] == HALT_OP)
        state_d = HALT_SEEN;
      else if (state_q == HALT_SEEN && pop && dec_instr[31:26] == HALT_OP)
        state_d = HALTED;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= RUN;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a reference queue holds expected entries,
// pushed when a fetch should be accepted and popped when decode takes one.
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic [31:0]   imemaddr, imemload;
  logic          ihit, redirect, dec_ready;
  logic          imemREN, pc_advance, dec_valid, halt;
  logic [31:0]   dec_instr, dec_pc, dec_npc;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;

  entry_t exp_q[$];
  int     m_state;           // 0 RUN, 1 HALT_SEEN, 2 HALTED
  logic [31:0] pc_var;
  int     halt_seen_ever;

  fetch_buffer #(.DEPTH(DEPTH), .HALT_OP(6'b111111)) dut (
    .CLK(CLK), .RST(RST), .imemaddr(imemaddr), .imemload(imemload),
    .ihit(ihit), .imemREN(imemREN), .pc_advance(pc_advance),
    .redirect(redirect), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_npc(dec_npc),
    .count(count), .halt(halt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] op_instr(input logic [31:0] a);
    return 32'h2000_0000 | (a & 32'h0000_FFFF);
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model just
  // before the edge, then advance the model the way the edge should.
  task automatic step(input logic rst, input logic hit, input logic [31:0] addr,
                      input logic [31:0] load, input logic rdy, input logic redir);
    logic   ren_m, push_m, valid_m, pop_m;
    entry_t head, e;
    RST = rst; ihit = hit; imemaddr = addr; imemload = load;
    dec_ready = rdy; redirect = redir;
    #3;
    ren_m   = (m_state == 0) && (exp_q.size() < DEPTH);
    valid_m = (exp_q.size() != 0) && (m_state != 2);
    push_m  = hit && ren_m && !redir;
    pop_m   = valid_m && rdy && !redir;
    check("imemREN", 64'(imemREN), 64'(ren_m));
    check("pc_advance", 64'(pc_advance), 64'(push_m));
    check("dec_valid", 64'(dec_valid), 64'(valid_m));
    check("count", 64'(count), 64'(exp_q.size()));
    check("halt", 64'(halt), 64'(m_state == 2));
    if (valid_m) begin
      check("dec_pc", 64'(dec_pc), 64'(exp_q[0].pc));
      check("dec_instr", 64'(dec_instr), 64'(exp_q[0].instr));
      check("dec_npc", 64'(dec_npc), 64'(exp_q[0].pc + 32'd4));
    end
    if (rst) begin
      exp_q.delete();
      m_state = 0;
    end else if (redir && m_state != 2) begin
      exp_q.delete();
      if (m_state == 1) m_state = 0;
    end else begin
      if (pop_m) begin
        head = exp_q.pop_front();
        if (m_state == 1 && head.instr[31:26] == 6'h3F) m_state = 2;
      end
      if (push_m) begin
        e.instr = load; e.pc = addr;
        exp_q.push_back(e);
        if (m_state == 0 && load[31:26] == 6'h3F) m_state = 1;
      end
    end
    if (m_state == 2) halt_seen_ever = 1;
    if (push_m) pc_var = addr + 32'd4;
    @(posedge CLK); #1;
  endtask

  task automatic fetch(input logic rdy);
    step(1'b0, 1'b1, pc_var, op_instr(pc_var), rdy, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    pc_var = 32'h0;
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; imemaddr = '0; imemload = '0;
    dec_ready = 1'b0; redirect = 1'b0;
    m_state = 0; pc_var = 0; halt_seen_ever = 0;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    #3;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(dec_valid), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_imemREN", 64'(imemREN), 64'd1);
    check("rst_pc_advance", 64'(pc_advance), 64'd0);
    check("rst_dec_instr", 64'(dec_instr), 64'd0);
    check("rst_dec_pc", 64'(dec_pc), 64'd0);
    @(posedge CLK); #1;

    // Streaming with decode always ready: one entry in flight.
    for (int i = 0; i < 6; i++) fetch(1'b1);
    // Decode stalled: fill to full, fetch throttled.
    for (int i = 0; i < 6; i++) fetch(1'b0);
    // Decode resumes: drain in order and refill across the wrap.
    for (int i = 0; i < 10; i++) fetch(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Redirect flush with a same-cycle hit that must be dropped.
    do_reset();
    pc_var = 32'h10;
    for (int i = 0; i < 3; i++) fetch(1'b0);
    step(1'b0, 1'b1, 32'h1C, op_instr(32'h1C), 1'b0, 1'b1);
    check("redir_count", 64'(count), 64'd0);
    check("redir_valid", 64'(dec_valid), 64'd0);
    pc_var = 32'h40;
    fetch(1'b1);
    check("redir_new_pc", 64'(dec_pc), 64'h40);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // HALT queued behind a normal instruction, then delivered.
    do_reset();
    pc_var = 32'h4;
    fetch(1'b0);
    step(1'b0, 1'b1, 32'h8, 32'hFC00_0000, 1'b0, 1'b0);
    check("halt_seen_ren", 64'(imemREN), 64'd0);
    step(1'b0, 1'b1, 32'hC, op_instr(32'hC), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'hC, op_instr(32'hC), 1'b1, 1'b0);
    check("halted", 64'(halt), 64'd1);
    step(1'b0, 1'b1, 32'h80, op_instr(32'h80), 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("halt_sticky", 64'(halt), 64'd1);

    // HALT squashed by a redirect before it pops.
    do_reset();
    halt_seen_ever = 0;
    pc_var = 32'h20;
    step(1'b0, 1'b1, 32'h20, 32'hFC00_0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("unhalt_ren", 64'(imemREN), 64'd1);
    pc_var = 32'h100;
    for (int i = 0; i < 4; i++) fetch(1'b1);
    check("halt_never", 64'(halt_seen_ever), 64'd0);

    // Reset mid-stream with three entries queued.
    do_reset();
    for (int i = 0; i < 3; i++) fetch(1'b0);
    check("pre_rst_count", 64'(count), 64'd3);
    do_reset();
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_valid", 64'(dec_valid), 64'd0);
    check("mid_rst_halt", 64'(halt), 64'd0);
    check("mid_rst_ren", 64'(imemREN), 64'd1);

    // Randomised traffic without HALTs.
    for (int i = 0; i < 60; i++)
      step(1'b0, 1'($urandom_range(0, 1)), pc_var, op_instr(pc_var),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
